pwm_cmd_ctrl: RTL and testbench

Command-sequencing controller between the USB endpoint byte stream and the PWM channel generators. It parses 2-byte host commands from the RX endpoint and keeps per-channel frequency and duty settings. For each channel it computes the period and compare counts with sequential dividers and commits them atomically with an update strobe. It optionally returns a 3-byte readback packet on the TX endpoint.

---
 rtl/pwm_cmd_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_pwm_cmd_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cmd_ctrl.sv
// rtl/pwm_cmd_ctrl.sv - USB command sequencer for PWM period/compare settings
// Optional readback path (READ op, response buffer, TX endpoint) under PWM_CMD_READBACK_EN.
module pwm_cmd_ctrl #(
  parameter int NCH  = 2,
  parameter int BASE = 1000,
  parameter int CW   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rxact,
  input  logic                rxval,
  input  logic [7:0]          rxdat,
  output logic                rxrdy,
  input  logic                txact,
  input  logic                txpop,
  output logic                txval,
  output logic                txcork,
  output logic [7:0]          txdat,
  output logic [11:0]         txdat_len,
  output logic [NCH*CW-1:0]   period_o,
  output logic [NCH*CW-1:0]   cmp_o,
  output logic [NCH-1:0]      upd
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW  = $clog2(CW);

  typedef enum logic [2:0] {
    S_IDLE, S_ARG, S_DIV1, S_MUL, S_DIV2, S_COMMIT, S_RESP_LOAD
  } state_t;

  state_t          state;
  logic [1:0]      op;
  logic [4:0]      ch;
  logic            err;
  logic [6:0]      freq [NCH];
  logic [6:0]      duty [NCH];
  logic [6:0]      wf, wd;
  logic [CW-1:0]   quo, rem, dvs, per;
  logic [SW-1:0]   cnt;

  logic [CHW-1:0]  chi;
  logic            ch_bad;
  logic            acc;
  logic [6:0]      val;
  logic [6:0]      duty_clamped;

  assign chi          = ch[CHW-1:0];
  assign ch_bad       = ({1'b0, ch} >= 6'(NCH));
  assign acc          = rxact & rxval & rxrdy;
  assign val          = rxdat[6:0];
  assign duty_clamped = (val > 7'd100) ? 7'd100 : val;

  // One restoring-divide step: quo shifts the dividend out and the quotient in.
  logic [CW:0]     trial;
  logic            ge;
  logic [CW-1:0]   rem_n, quo_n, prod_lo;

  always_comb begin
    trial = {rem, quo[CW-1]};
    ge    = (trial >= {1'b0, dvs});
    rem_n = ge ? CW'(trial - {1'b0, dvs}) : trial[CW-1:0];
    quo_n = {quo[CW-2:0], ge};
  end

  // Only the low CW bits of period*duty feed the second divide.
  assign prod_lo = quo * CW'(wd);

`ifdef PWM_CMD_READBACK_EN
  logic            pending;
  logic [1:0]      ptr;
  logic [7:0]      rb0, rb1, rb2;
  logic            pop;
  logic            last_pop;

  assign pop       = pending & txact & txpop;
  assign last_pop  = pop & (ptr == 2'd2);
  assign txval     = pending;
  assign txcork    = ~pending;
  assign txdat_len = pending ? 12'd3 : 12'd0;
`else
  logic            unused_tx;
  assign unused_tx = txact ^ txpop;
  assign txval     = 1'b0;
  assign txcork    = 1'b1;
  assign txdat     = 8'h00;
  assign txdat_len = 12'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      rxrdy <= 1'b1;
      op    <= '0;
      ch    <= '0;
      err   <= 1'b0;
      wf    <= '0;
      wd    <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      per   <= '0;
      cnt   <= '0;
      upd   <= '0;
      for (int i = 0; i < NCH; i++) begin
        freq[i]              <= 7'd1;
        duty[i]              <= 7'd0;
        period_o[i*CW +: CW] <= CW'(BASE);
        cmp_o[i*CW +: CW]    <= '0;
      end
`ifdef PWM_CMD_READBACK_EN
      pending <= 1'b0;
      ptr     <= '0;
      rb0     <= '0;
      rb1     <= '0;
      rb2     <= '0;
      txdat   <= '0;
`endif
    end else begin
      upd <= '0;

`ifdef PWM_CMD_READBACK_EN
      // TX path first so that command errors below take precedence over the pop-clear of err.
      if (state == S_RESP_LOAD) begin
        rb0     <= {err, 2'b00, ch};
        rb1     <= {1'b0, freq[chi]};
        rb2     <= {1'b0, duty[chi]};
        txdat   <= {err, 2'b00, ch};
        pending <= 1'b1;
        ptr     <= '0;
      end else if (pop) begin
        case (ptr)
          2'd0: begin
            err   <= 1'b0;
            ptr   <= 2'd1;
            txdat <= rb1;
          end
          2'd1: begin
            ptr   <= 2'd2;
            txdat <= rb2;
          end
          default: begin
            ptr     <= '0;
            pending <= 1'b0;
            txdat   <= '0;
          end
        endcase
      end else if (!txact) begin
        ptr   <= '0;
        txdat <= pending ? rb0 : 8'h00;
      end
`endif

      case (state)
        S_IDLE: begin
          if (acc) begin
            op    <= rxdat[7:6];
            ch    <= rxdat[4:0];
            state <= S_ARG;
          end
        end
        S_ARG: begin
          if (!rxact) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else if (acc) begin
            state <= S_IDLE;
            if (ch_bad) begin
              err <= 1'b1;
            end else begin
              case (op)
                2'b00: begin
                  if (val == 7'd0) begin
                    err <= 1'b1;
                  end else begin
                    wf    <= val;
                    wd    <= duty[chi];
                    dvs   <= CW'(val);
                    quo   <= CW'(BASE);
                    rem   <= '0;
                    cnt   <= '0;
                    rxrdy <= 1'b0;
                    state <= S_DIV1;
                  end
                end
                2'b01: begin
                  wf    <= freq[chi];
                  wd    <= duty_clamped;
                  dvs   <= CW'(freq[chi]);
                  quo   <= CW'(BASE);
                  rem   <= '0;
                  cnt   <= '0;
                  rxrdy <= 1'b0;
                  state <= S_DIV1;
                end
`ifdef PWM_CMD_READBACK_EN
                2'b10: begin
                  // A response finishing on this very edge does not count as pending.
                  if (pending && !last_pop) begin
                    err <= 1'b1;
                  end else begin
                    rxrdy <= 1'b0;
                    state <= S_RESP_LOAD;
                  end
                end
`endif
                default: err <= 1'b1;
              endcase
            end
          end
        end
        S_DIV1: begin
          quo <= quo_n;
          rem <= rem_n;
          cnt <= cnt + 1'b1;
          if (cnt == SW'(CW - 1)) state <= S_MUL;
        end
        S_MUL: begin
          per   <= quo;
          quo   <= prod_lo;
          rem   <= '0;
          dvs   <= CW'(100);
          cnt   <= '0;
          state <= S_DIV2;
        end
        S_DIV2: begin
          quo <= quo_n;
          rem <= rem_n;
          cnt <= cnt + 1'b1;
          if (cnt == SW'(CW - 1)) state <= S_COMMIT;
        end
        S_COMMIT: begin
          period_o[chi*CW +: CW] <= per;
          cmp_o[chi*CW +: CW]    <= quo;
          freq[chi]              <= wf;
          duty[chi]              <= wd;
          upd[chi]               <= 1'b1;
          rxrdy                  <= 1'b1;
          state                  <= S_IDLE;
        end
        S_RESP_LOAD: begin
          rxrdy <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          rxrdy <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_cmd_ctrl.sv
// tb/tb_pwm_cmd_ctrl.sv - scoreboard bench for pwm_cmd_ctrl
// Readback checks run only when PWM_CMD_READBACK_EN is defined.
module tb_pwm_cmd_ctrl;
  localparam int NCH = 2;
  localparam int CW  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rxact = 1'b0;
  logic              rxval = 1'b0;
  logic [7:0]        rxdat = 8'h00;
  logic              txact = 1'b0;
  logic              txpop = 1'b0;
  logic              rxrdy, txval, txcork;
  logic [7:0]        txdat;
  logic [11:0]       txdat_len;
  logic [NCH*CW-1:0] period_o, cmp_o;
  logic [NCH-1:0]    upd;

  pwm_cmd_ctrl #(.NCH(NCH), .BASE(1000), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .rxact(rxact), .rxval(rxval), .rxdat(rxdat), .rxrdy(rxrdy),
    .txact(txact), .txpop(txpop), .txval(txval), .txcork(txcork),
    .txdat(txdat), .txdat_len(txdat_len),
    .period_o(period_o), .cmp_o(cmp_o), .upd(upd)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [NCH-1:0] mask;
    logic [CW-1:0]  per;
    logic [CW-1:0]  cmp;
    int             at_edge;
    int             ch;
  } upd_exp_t;

  upd_exp_t   upd_q[$];
  logic [7:0] tx_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_upd(input int c, input int p, input int m, input int a);
    upd_exp_t e;
    e.mask    = NCH'(1) << c;
    e.per     = CW'(p);
    e.cmp     = CW'(m);
    e.at_edge = a + 66;
    e.ch      = c;
    upd_q.push_back(e);
  endtask

  // Update monitor: every upd pulse must match the next queued expectation.
  initial begin
    upd_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && upd != '0) begin
        if (upd_q.size() == 0) begin
          check("unexpected_upd", 64'(upd), 64'd0);
        end else begin
          e = upd_q.pop_front();
          check("upd_mask",   64'(upd), 64'(e.mask));
          check("upd_period", 64'(period_o[e.ch*CW +: CW]), 64'(e.per));
          check("upd_cmp",    64'(cmp_o[e.ch*CW +: CW]), 64'(e.cmp));
          check("upd_edge",   64'(edges), 64'(e.at_edge));
        end
      end
    end
  end

  // TX monitor: the byte on txdat during an accepted pop is the one consumed.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && txact && txpop && txval) begin
        if (tx_q.size() == 0) begin
          check("unexpected_tx", 64'(txdat), 64'd0);
        end else begin
          b = tx_q.pop_front();
          check("tx_byte", 64'(txdat), 64'(b));
        end
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!rxrdy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(nm, 64'(rxrdy), 64'd1);
  endtask

  // Returns with edges equal to the edge that accepted byte1.
  task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1, output int a);
    wait_idle("rxrdy_before_cmd");
    rxact = 1'b1; rxval = 1'b1; rxdat = b0;
    @(posedge clk); #1;
    rxdat = b1;
    a = edges + 1;
    @(posedge clk); #1;
    rxval = 1'b0; rxact = 1'b0; rxdat = 8'h00;
  endtask

  task automatic pop_byte();
    txact = 1'b1; txpop = 1'b1;
    @(posedge clk); #1;
    txpop = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_period0", 64'(period_o[0 +: CW]), 64'd1000);
    check("rst_period1", 64'(period_o[CW +: CW]), 64'd1000);
    check("rst_cmp",     64'(cmp_o), 64'd0);
    check("rst_upd",     64'(upd), 64'd0);
    check("rst_rxrdy",   64'(rxrdy), 64'd1);
    check("rst_txcork",  64'(txcork), 64'd1);
    check("rst_txval",   64'(txval), 64'd0);
    check("rst_txdat",   64'(txdat), 64'd0);
    check("rst_txlen",   64'(txdat_len), 64'd0);

    // SET_FREQ ch0=10 with duty 0, then SET_DUTY ch0=25.
    send_cmd(8'h00, 8'h0A, a); expect_upd(0, 100, 0, a);  wait_idle("idle_f0");
    send_cmd(8'h40, 8'h19, a); expect_upd(0, 100, 25, a); wait_idle("idle_d0");

    // ch1: 1000/3=333, duty 50 -> 166; duty 120 clamps to 100; bit7 of value ignored.
    send_cmd(8'h01, 8'h03, a); expect_upd(1, 333, 0, a);   wait_idle("idle_f1");
    send_cmd(8'h41, 8'h32, a); expect_upd(1, 333, 166, a); wait_idle("idle_d1");
    send_cmd(8'h41, 8'h78, a); expect_upd(1, 333, 333, a); wait_idle("idle_clamp");
    send_cmd(8'h41, 8'hB2, a); expect_upd(1, 333, 166, a); wait_idle("idle_bit7");
    idle_cycles(2);
    check("ch0_period_kept", 64'(period_o[0 +: CW]), 64'd100);
    check("ch0_cmp_kept",    64'(cmp_o[0 +: CW]), 64'd25);

    // Rejected commands: freq 0, channel 5, reserved op.
    send_cmd(8'h00, 8'h00, a); wait_idle("idle_err_f0");
    send_cmd(8'h05, 8'h0A, a); wait_idle("idle_err_ch");
    send_cmd(8'hC0, 8'h0A, a); wait_idle("idle_err_op");
    idle_cycles(80);
    check("err_period0", 64'(period_o[0 +: CW]), 64'd100);
    check("err_cmp0",    64'(cmp_o[0 +: CW]), 64'd25);
    check("err_period1", 64'(period_o[CW +: CW]), 64'd333);

`ifdef PWM_CMD_READBACK_EN
    tx_q.push_back(8'h80); tx_q.push_back(8'h0A); tx_q.push_back(8'h19);
    send_cmd(8'h80, 8'h00, a);
    @(posedge clk); #1;
    check("rd_txval",  64'(txval), 64'd1);
    check("rd_txcork", 64'(txcork), 64'd0);
    check("rd_txlen",  64'(txdat_len), 64'd3);
    check("rd_status", 64'(txdat), 64'h80);
    pop_byte(); pop_byte(); pop_byte();
    check("rd_done_txval",  64'(txval), 64'd0);
    check("rd_done_txcork", 64'(txcork), 64'd1);
    check("rd_done_txlen",  64'(txdat_len), 64'd0);

    tx_q.push_back(8'h00); tx_q.push_back(8'h0A); tx_q.push_back(8'h19);
    send_cmd(8'h80, 8'h00, a);
    @(posedge clk); #1;
    pop_byte(); pop_byte(); pop_byte();

    tx_q.push_back(8'h01);
    send_cmd(8'h81, 8'h00, a);
    @(posedge clk); #1;
    pop_byte();
    txact = 1'b0;
    @(posedge clk); #1;
    txact = 1'b1;
    check("tx_restart_byte",  64'(txdat), 64'h01);
    check("tx_restart_valid", 64'(txval), 64'd1);
    // READ while pending leaves the stored response alone.
    send_cmd(8'h80, 8'h00, a);
    idle_cycles(2);
    tx_q.push_back(8'h01); tx_q.push_back(8'h03); tx_q.push_back(8'h32);
    pop_byte(); pop_byte(); pop_byte();
    check("rd1_done_txval",  64'(txval), 64'd0);
    check("rd1_done_txcork", 64'(txcork), 64'd1);
    txact = 1'b0;
`else
    send_cmd(8'h80, 8'h00, a);
    idle_cycles(3);
    check("nord_txval",  64'(txval), 64'd0);
    check("nord_txcork", 64'(txcork), 64'd1);
    check("nord_txdat",  64'(txdat), 64'd0);
    check("nord_txlen",  64'(txdat_len), 64'd0);
    check("nord_rxrdy",  64'(rxrdy), 64'd1);
`endif

    // rxact drops after byte0: the next byte must be parsed as a fresh byte0.
    wait_idle("idle_abort");
    rxact = 1'b1; rxval = 1'b1; rxdat = 8'h00;
    @(posedge clk); #1;
    rxval = 1'b0; rxact = 1'b0;
    @(posedge clk); #1;
    check("abort_rxrdy", 64'(rxrdy), 64'd1);
    send_cmd(8'h41, 8'h19, a); expect_upd(1, 333, 83, a); wait_idle("idle_after_abort");
    idle_cycles(2);

    // Reset sampled on DIV1 step 10 abandons the computation.
    send_cmd(8'h00, 8'h14, a);
    idle_cycles(9);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_rxrdy",   64'(rxrdy), 64'd1);
    check("midrst_period0", 64'(period_o[0 +: CW]), 64'd1000);
    idle_cycles(80);
    check("midrst_period0_later", 64'(period_o[0 +: CW]), 64'd1000);
    check("midrst_cmp_later",     64'(cmp_o), 64'd0);
    check("midrst_rxrdy_later",   64'(rxrdy), 64'd1);

    check("upd_queue_drained", 64'(upd_q.size()), 64'd0);
    check("tx_queue_drained",  64'(tx_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
